// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg: shared defaults, stage-entry layout and readiness conventions     |
// | for the post-execute pipeline and its forwarding network.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int REG_AW_DEF    = 3;
    localparam int DEPTH_DEF     = 4;
    localparam int NRD_DEF       = 2;
    localparam int UPD_STAGE_DEF = 1;
    localparam int RDY_W_DEF     = $clog2(DEPTH_DEF);

    // ALU results are final on entry; loads become final once past the update stage.
    localparam int RDY_ALU      = 0;
    localparam int RDY_LOAD_DEF = UPD_STAGE_DEF + 1;

    function automatic int rdy_load(input int upd_stage);
        return upd_stage + 1;
    endfunction

    typedef struct packed {
        logic                  v;
        logic [DATA_W_DEF-1:0] res;
        logic [REG_AW_DEF-1:0] dst;
        logic                  we;
        logic [RDY_W_DEF-1:0]  rdy;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/pipe_bypass_chain_bypass_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bypass_match: one forwarding read port; youngest matching stage wins.      |
// | Option: R0_ZERO_EN forces reads of register 0 to zero.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bypass_match #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 4
) (
    input  logic [DEPTH-1:0]        cand_i,
    input  logic [DEPTH-1:0]        ready_i,
    input  logic [DEPTH*REG_AW-1:0] dst_i,
    input  logic [DEPTH*DATA_W-1:0] res_i,
    input  logic [REG_AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]       rf_data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    hazard_o
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand_i[i] && (dst_i[i*REG_AW +: REG_AW] == addr_i)) begin
                data_o   = res_i[i*DATA_W +: DATA_W];
                hazard_o = ~ready_i[i];
            end
        end
`ifdef R0_ZERO_EN
        if (addr_i == '0) begin
            data_o   = '0;
            hazard_o = 1'b0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/pipe_bypass_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_bypass_chain: DEPTH-stage ALU-to-writeback pipe with NRD-port         |
// | forwarding and load-use hazard detection. Option: R0_ZERO_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_bypass_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NRD       = NRD_DEF,
    parameter int UPD_STAGE = UPD_STAGE_DEF
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_result_i,
    input  logic [REG_AW-1:0]          in_dest_i,
    input  logic                       in_we_i,
    input  logic [$clog2(DEPTH)-1:0]   in_rdy_i,
    input  logic                       upd_valid_i,
    input  logic [DATA_W-1:0]          upd_result_i,
    input  logic [NRD*REG_AW-1:0]      rd_addr_i,
    input  logic [NRD*DATA_W-1:0]      rd_rf_data_i,
    output logic [NRD*DATA_W-1:0]      rd_data_o,
    output logic [NRD-1:0]             rd_hazard_o,
    output logic                       wb_we_o,
    output logic [REG_AW-1:0]          wb_dest_o,
    output logic [DATA_W-1:0]          wb_result_o
);

    localparam int RW = $clog2(DEPTH);

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] res;
        logic [REG_AW-1:0] dst;
        logic              we;
        logic [RW-1:0]     rdy;
    } ent_t;

    ent_t                   stg_q [DEPTH];
    ent_t                   stg_d [DEPTH];
    logic [RW-1:0]          w_rdy_in;
    logic [DEPTH-1:0]       w_cand;
    logic [DEPTH-1:0]       w_ready;
    logic [DEPTH*REG_AW-1:0] w_dst_flat;
    logic [DEPTH*DATA_W-1:0] w_res_flat;

    // Out-of-range readiness is clamped to writeback so the op is never stuck.
    assign w_rdy_in = ({1'b0, in_rdy_i} > (RW+1)'(DEPTH-1)) ? RW'(DEPTH-1) : in_rdy_i;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stg_d[i] = stg_q[i];
        end
        if (enable_i) begin
            stg_d[0] = '{v: in_valid_i, res: in_result_i, dst: in_dest_i,
                         we: in_we_i, rdy: w_rdy_in};
            for (int i = 1; i < DEPTH; i++) begin
                stg_d[i] = stg_q[i-1];
            end
            if (upd_valid_i && stg_q[UPD_STAGE].v) begin
                stg_d[UPD_STAGE+1].res = upd_result_i;
            end
        end
        if (flush_i) begin
            stg_d[0].v = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset_i) begin
                stg_q[i] <= '0;
            end else begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_flat
`ifdef R0_ZERO_EN
            assign w_cand[i] = stg_q[i].v & stg_q[i].we & (|stg_q[i].dst);
`else
            assign w_cand[i] = stg_q[i].v & stg_q[i].we;
`endif
            assign w_ready[i]                       = (RW'(i) >= stg_q[i].rdy);
            assign w_dst_flat[i*REG_AW +: REG_AW]   = stg_q[i].dst;
            assign w_res_flat[i*DATA_W +: DATA_W]   = stg_q[i].res;
        end

        for (genvar p = 0; p < NRD; p++) begin : g_port
            bypass_match #(
                .DATA_W (DATA_W),
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH)
            ) u_match (
                .cand_i    (w_cand),
                .ready_i   (w_ready),
                .dst_i     (w_dst_flat),
                .res_i     (w_res_flat),
                .addr_i    (rd_addr_i[p*REG_AW +: REG_AW]),
                .rf_data_i (rd_rf_data_i[p*DATA_W +: DATA_W]),
                .data_o    (rd_data_o[p*DATA_W +: DATA_W]),
                .hazard_o  (rd_hazard_o[p])
            );
        end
    endgenerate

    assign wb_we_o     = w_cand[DEPTH-1];
    assign wb_dest_o   = stg_q[DEPTH-1].dst;
    assign wb_result_o = stg_q[DEPTH-1].res;

    a_rdy_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        in_valid_i |-> ({1'b0, in_rdy_i} <= (RW+1)'(DEPTH-1)));

endmodule
`default_nettype wire

// File: tb/tb_pipe_bypass_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_bypass_chain: self-checking bench, forwarding vector table plus    |
// | writeback scoreboard. Honors R0_ZERO_EN when defined.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_bypass_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_result;
    logic [2:0]  in_dest;
    logic        in_we;
    logic [1:0]  in_rdy;
    logic        upd_valid;
    logic [15:0] upd_result;
    logic [5:0]  rd_addr;
    logic [31:0] rd_rf;
    logic [31:0] rd_data;
    logic [1:0]  rd_haz;
    logic        wb_we;
    logic [2:0]  wb_dest;
    logic [15:0] wb_result;

    int checks = 0;
    int errors = 0;
    logic [18:0] sb [$];
    logic        adv = 1'b0;

    typedef struct {
        logic [2:0]  a0, a1;
        logic [15:0] rf0, rf1;
        logic [15:0] d0, d1;
        logic        h0, h1;
        logic        c0, c1;
    } vec_t;
    vec_t tbl [5];

    pipe_bypass_chain dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_result_i  (in_result),
        .in_dest_i    (in_dest),
        .in_we_i      (in_we),
        .in_rdy_i     (in_rdy),
        .upd_valid_i  (upd_valid),
        .upd_result_i (upd_result),
        .rd_addr_i    (rd_addr),
        .rd_rf_data_i (rd_rf),
        .rd_data_o    (rd_data),
        .rd_hazard_o  (rd_haz),
        .wb_we_o      (wb_we),
        .wb_dest_o    (wb_dest),
        .wb_result_o  (wb_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // A write is new only when the preceding edge advanced the pipe.
    always @(posedge clk) adv <= enable && !reset;

    always @(negedge clk) begin
        if (adv && wb_we) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {13'd0, wb_dest, wb_result}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                chk("wb_write", {13'd0, wb_dest, wb_result}, {13'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1'b1; flush = 1'b0; in_valid = 1'b0; upd_valid = 1'b0;
        in_rdy = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [2:0] d, input logic [15:0] r, input logic we,
                         input logic [1:0] rdy, input logic push, input logic [15:0] wbv);
        enable = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_dest = d; in_result = r; in_we = we; in_rdy = rdy;
        if (push) sb.push_back({d, wbv});
        tick();
        in_valid = 1'b0; in_rdy = 2'd0;
    endtask

    task automatic apply_table(input string tag);
        for (int k = 0; k < 5; k++) begin
            rd_addr = {tbl[k].a1, tbl[k].a0};
            rd_rf   = {tbl[k].rf1, tbl[k].rf0};
            #1;
            if (tbl[k].c0) chk({tag, "_d0"}, {16'd0, rd_data[15:0]}, {16'd0, tbl[k].d0});
            if (tbl[k].c1) chk({tag, "_d1"}, {16'd0, rd_data[31:16]}, {16'd0, tbl[k].d1});
            chk({tag, "_h0"}, {31'd0, rd_haz[0]}, {31'd0, tbl[k].h0});
            chk({tag, "_h1"}, {31'd0, rd_haz[1]}, {31'd0, tbl[k].h1});
        end
    endtask

    initial begin
        // Pipe content while stalled: s0=r5 load(not ready) s1=r2:0022 s2=r2:0011 s3=r6 we=0
        tbl[0] = '{3'd2, 3'd5, 16'hFFFF, 16'hEEEE, 16'h0022, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{3'd6, 3'd1, 16'h1357, 16'h2468, 16'h1357, 16'h2468, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{3'd5, 3'd2, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h0022, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{3'd3, 3'd7, 16'h0003, 16'h0007, 16'h0003, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef R0_ZERO_EN
        tbl[4] = '{3'd0, 3'd4, 16'h0100, 16'h0400, 16'h0000, 16'h0400, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        tbl[4] = '{3'd0, 3'd4, 16'h0100, 16'h0400, 16'h0100, 16'h0400, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        in_dest = 3'd0; in_result = 16'd0; in_we = 1'b0; upd_result = 16'd0;
        rd_addr = 6'd0; rd_rf = 32'h0000_0000;

        // Reset state
        do_reset();
        rd_addr = {3'd3, 3'd1}; rd_rf = 32'hA5A5_5A5A; #1;
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_dest", {29'd0, wb_dest}, 32'd0);
        chk("rst_wb_result", {16'd0, wb_result}, 32'd0);
        chk("rst_rd_data", rd_data, 32'hA5A5_5A5A);

        // Basic write: latency of DEPTH edges to WB
        issue(3'd3, 16'h1234, 1'b1, 2'(pipe_pkg::RDY_ALU), 1'b1, 16'h1234);
        idle(); tick(); tick();
        chk("t1_wb_early", {31'd0, wb_we}, 32'd0);
        tick();
        chk("t1_wb_we", {31'd0, wb_we}, 32'd1);
        chk("t1_wb", {13'd0, wb_dest, wb_result}, {13'd0, 3'd3, 16'h1234});
        tick(); tick(); tick();

        // Forwarding table against a frozen pipe, then hold check
        do_reset();
        issue(3'd6, 16'h6666, 1'b0, 2'd0, 1'b0, 16'h0);
        issue(3'd2, 16'h0011, 1'b1, 2'd0, 1'b1, 16'h0011);
        issue(3'd2, 16'h0022, 1'b1, 2'd0, 1'b1, 16'h0022);
        issue(3'd5, 16'h5A5A, 1'b1, 2'(pipe_pkg::RDY_LOAD_DEF), 1'b1, 16'h5A5A);
        enable = 1'b0;
        apply_table("fwd");
        tick(); tick(); tick();
        chk("stall_wb_we", {31'd0, wb_we}, 32'd0);
        apply_table("hold");
        enable = 1'b1; rd_addr = {3'd5, 3'd0}; rd_rf = 32'h0;
        tick(); #1;
        chk("ld_s1_haz", {31'd0, rd_haz[1]}, 32'd1);
        tick(); #1;
        chk("ld_s2_haz", {31'd0, rd_haz[1]}, 32'd0);
        chk("ld_s2_data", {16'd0, rd_data[31:16]}, 32'h5A5A);
        tick(); tick();

        // Late data replaces a load result on its way out of the update stage
        do_reset();
        issue(3'd5, 16'h0000, 1'b1, 2'(pipe_pkg::rdy_load(1)), 1'b1, 16'hBEEF);
        rd_addr = {3'd5, 3'd0}; rd_rf = 32'h1111_2222; #1;
        chk("t3_s0_haz", {31'd0, rd_haz[1]}, 32'd1);
        idle(); tick();
        chk("t3_s1_haz", {31'd0, rd_haz[1]}, 32'd1);
        upd_valid = 1'b1; upd_result = 16'hBEEF;
        tick();
        upd_valid = 1'b0; #1;
        chk("t3_s2_haz", {31'd0, rd_haz[1]}, 32'd0);
        chk("t3_s2_data", {16'd0, rd_data[31:16]}, 32'hBEEF);
        tick(); tick(); tick();

        // Stall with flush: held op resumes, flushed op never writes
        do_reset();
        issue(3'd4, 16'h4444, 1'b1, 2'd0, 1'b1, 16'h4444);
        idle(); tick();
        issue(3'd7, 16'h7777, 1'b1, 2'd0, 1'b0, 16'h0);
        enable = 1'b0; rd_addr = {3'd7, 3'd4}; rd_rf = 32'h0F0F_F0F0; #1;
        chk("t4_pre_d0", {16'd0, rd_data[15:0]}, 32'h4444);
        chk("t4_pre_d1", {16'd0, rd_data[31:16]}, 32'h7777);
        flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        chk("t4_flushed_d1", {16'd0, rd_data[31:16]}, 32'h0F0F);
        tick(); tick(); #1;
        chk("t4_hold_d0", {16'd0, rd_data[15:0]}, 32'h4444);
        chk("t4_hold_wb", {31'd0, wb_we}, 32'd0);
        enable = 1'b1;
        tick();
        chk("t4_wb", {12'd0, wb_we, wb_dest, wb_result}, {12'd0, 1'b1, 3'd4, 16'h4444});
        tick(); tick(); tick();

        // Reset with four ops in flight
        do_reset();
        issue(3'd1, 16'h0101, 1'b1, 2'd0, 1'b1, 16'h0101);
        issue(3'd2, 16'h0202, 1'b1, 2'd0, 1'b0, 16'h0);
        issue(3'd3, 16'h0303, 1'b1, 2'd0, 1'b0, 16'h0);
        issue(3'd4, 16'h0404, 1'b1, 2'd0, 1'b0, 16'h0);
        rd_addr = {3'd2, 3'd4}; rd_rf = 32'hCCCC_DDDD; #1;
        chk("t5_pre", rd_data, 32'h0202_0404);
        reset = 1'b1;
        tick();
        chk("t5_wb_we", {31'd0, wb_we}, 32'd0);
        chk("t5_rd_data", rd_data, 32'hCCCC_DDDD);
        reset = 1'b0;
        tick(); tick(); tick(); tick();

        // Register 0 handling
        do_reset();
`ifdef R0_ZERO_EN
        issue(3'd0, 16'h5555, 1'b1, 2'd0, 1'b0, 16'h0);
`else
        issue(3'd0, 16'h5555, 1'b1, 2'd0, 1'b1, 16'h5555);
`endif
        rd_addr = {3'd1, 3'd0}; rd_rf = 32'h0000_9999; #1;
`ifdef R0_ZERO_EN
        chk("t6_r0_data", {16'd0, rd_data[15:0]}, 32'h0000);
`else
        chk("t6_r0_data", {16'd0, rd_data[15:0]}, 32'h5555);
`endif
        chk("t6_r0_haz", {31'd0, rd_haz[0]}, 32'd0);
        idle(); tick(); tick(); tick();
`ifdef R0_ZERO_EN
        chk("t6_wb_we", {31'd0, wb_we}, 32'd0);
`else
        chk("t6_wb_we", {31'd0, wb_we}, 32'd1);
`endif
        tick(); tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
